// File: rtl/gps_multich_dump_collector_pkg.sv
// Shared types and helpers for the multi-channel dump collector.
// GPS_DUMP_TSTAMP_EN adds a 32-bit capture timestamp to every record.
package gps_dump_pkg;

    localparam int ACC_W_DEF = 18;
    localparam int CH_W_DEF  = 4;
    localparam int NACC      = 6;
    localparam int EPOCH_W   = 16;

`ifdef GPS_DUMP_TSTAMP_EN
    localparam int TSTAMP_W   = 32;
    localparam int TS_FIELD_W = TSTAMP_W;
`else
    localparam int TS_FIELD_W = 0;
`endif

    // Record layout from the LSB up: [tstamp], epoch, acc, ch.
    function automatic int rec_epoch_lsb();
        return TS_FIELD_W;
    endfunction

    function automatic int rec_acc_lsb();
        return TS_FIELD_W + EPOCH_W;
    endfunction

    function automatic int rec_ch_lsb(input int acc_w);
        return TS_FIELD_W + EPOCH_W + NACC * acc_w;
    endfunction

    typedef struct packed {
        logic [CH_W_DEF-1:0]         ch;
        logic [NACC*ACC_W_DEF-1:0]   acc;
        logic [EPOCH_W-1:0]          epoch;
`ifdef GPS_DUMP_TSTAMP_EN
        logic [TSTAMP_W-1:0]         tstamp;
`endif
    } gps_rec_t;

    // Returns {found, index} of the first pending channel at or above rr_ptr,
    // wrapping modulo nch. Iterating downward lets the lowest offset win.
    function automatic logic [4:0] rr_pick(input logic [15:0] pending,
                                           input logic [3:0]  rr_ptr,
                                           input int          nch);
        logic [4:0] pick;
        int         idx;
        logic [3:0] idx4;
        pick = '0;
        for (int i = 15; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= nch) idx = idx - nch;
            idx4 = 4'(idx);
            if (i < nch && pending[idx4]) pick = {1'b1, idx4};
        end
        return pick;
    endfunction

endpackage

// File: rtl/gps_multich_dump_collector_if.sv
// Record stream from the dump collector to the bus-side wrapper.
// GPS_DUMP_TSTAMP_EN adds rec_tstamp.
interface gps_dump_rec_if
    import gps_dump_pkg::*;
#(
    parameter int CH_W  = CH_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic                    rec_valid;
    logic                    rec_ready;
    logic [CH_W-1:0]         rec_ch;
    logic [NACC*ACC_W-1:0]   rec_acc;
    logic [EPOCH_W-1:0]      rec_epoch;
`ifdef GPS_DUMP_TSTAMP_EN
    logic [31:0]             rec_tstamp;
`endif

    modport master (
        output rec_valid, rec_ch, rec_acc, rec_epoch,
`ifdef GPS_DUMP_TSTAMP_EN
        output rec_tstamp,
`endif
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_ch, rec_acc, rec_epoch,
`ifdef GPS_DUMP_TSTAMP_EN
        input  rec_tstamp,
`endif
        output rec_ready
    );
endinterface

// File: rtl/gps_sync_fifo.sv
// Synchronous FIFO with distributed-RAM storage, asynchronous head read and
// an occupancy output. DEPTH must be a power of two so pointers wrap freely.
module gps_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [AW:0]      level
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (level != '0);
    assign do_push = push && (level < FULL_LVL);
    assign do_pop  = pop && valid;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/gps_multich_dump_collector.sv
// Latches per-channel correlator dumps, round-robins them into a record FIFO.
// GPS_DUMP_TSTAMP_EN stores a free-running sample count with each record.
module gps_multich_dump_collector
    import gps_dump_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int ACC_W = ACC_W_DEF,
    parameter int DEPTH = 16,
    parameter int CH_W  = CH_W_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic [NCH-1:0]            dump,
    input  logic [NCH*NACC*ACC_W-1:0] acc_in,
    input  logic [NCH*EPOCH_W-1:0]    epoch_in,
    gps_dump_rec_if.master            rec,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [NCH-1:0]            overrun,
    input  logic [NCH-1:0]            ovr_clr,
    output logic [15:0]               drop_count
);
    localparam int ACCS_W    = NACC * ACC_W;
    localparam int HOLD_W    = ACCS_W + EPOCH_W + TS_FIELD_W;
    localparam int REC_W     = CH_W + HOLD_W;
    localparam int LVL_W     = $clog2(DEPTH) + 1;
    localparam int CH_LSB    = rec_ch_lsb(ACC_W);
    localparam int ACC_LSB   = rec_acc_lsb();
    localparam int EPOCH_LSB = rec_epoch_lsb();

    logic [HOLD_W-1:0] hold     [NCH];
    logic [HOLD_W-1:0] cap_data [NCH];
    logic [NCH-1:0]    pending;
    logic [CH_W-1:0]   rr_ptr;
    logic [4:0]        pick;
    logic              grant_any;
    logic [CH_W-1:0]   grant_ch;
    logic [NCH-1:0]    grant;
    logic [NCH-1:0]    ovr_set;
    logic [4:0]        ovr_cnt;
    logic [16:0]       drop_sum;
    logic [REC_W-1:0]  fifo_wdata;
    logic [REC_W-1:0]  fifo_rdata;
    logic              pop;

`ifdef GPS_DUMP_TSTAMP_EN
    logic [31:0] tstamp_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tstamp_cnt <= '0;
        else       tstamp_cnt <= tstamp_cnt + 32'd1;
    end

    always_comb begin
        for (int c = 0; c < NCH; c++)
            cap_data[c] = {acc_in[c*ACCS_W +: ACCS_W], epoch_in[c*EPOCH_W +: EPOCH_W], tstamp_cnt};
    end
`else
    always_comb begin
        for (int c = 0; c < NCH; c++)
            cap_data[c] = {acc_in[c*ACCS_W +: ACCS_W], epoch_in[c*EPOCH_W +: EPOCH_W]};
    end
`endif

    // Fullness is judged before any same-cycle pop; flush suppresses the grant.
    always_comb begin
        pick       = rr_pick(16'(pending), 4'(rr_ptr), NCH);
        grant_any  = pick[4] && (fifo_level < LVL_W'(DEPTH)) && !flush;
        grant_ch   = CH_W'(pick[3:0]);
        grant      = '0;
        fifo_wdata = '0;
        for (int c = 0; c < NCH; c++) begin
            grant[c] = grant_any && (pick[3:0] == 4'(c));
            if (grant[c]) fifo_wdata = {CH_W'(c), hold[c]};
        end
    end

    // A dump on the channel being granted replaces the hold after its old
    // contents are written, so it is not an overrun.
    always_comb begin
        ovr_set = dump & pending & ~grant & {NCH{~flush}};
        ovr_cnt = '0;
        for (int c = 0; c < NCH; c++) ovr_cnt = ovr_cnt + 5'(ovr_set[c]);
        drop_sum = {1'b0, drop_count} + 17'(ovr_cnt);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
            for (int c = 0; c < NCH; c++) hold[c] <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (flush) begin
                    pending[c] <= 1'b0;
                end else if (dump[c]) begin
                    hold[c]    <= cap_data[c];
                    pending[c] <= 1'b1;
                end else if (grant[c]) begin
                    pending[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr     <= '0;
            overrun    <= '0;
            drop_count <= '0;
        end else begin
            if (flush)
                rr_ptr <= '0;
            else if (grant_any)
                rr_ptr <= (grant_ch == CH_W'(NCH-1)) ? '0 : grant_ch + CH_W'(1);
            overrun    <= (overrun & ~ovr_clr) | ovr_set;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign pop = rec.rec_valid && rec.rec_ready;

    gps_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .push  (grant_any),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (rec.rec_valid),
        .level (fifo_level)
    );

    assign rec.rec_ch    = fifo_rdata[CH_LSB +: CH_W];
    assign rec.rec_acc   = fifo_rdata[ACC_LSB +: ACCS_W];
    assign rec.rec_epoch = fifo_rdata[EPOCH_LSB +: EPOCH_W];
`ifdef GPS_DUMP_TSTAMP_EN
    assign rec.rec_tstamp = fifo_rdata[31:0];
`endif
endmodule

// File: doc/gps_multich_dump_collector.md
Name: gps_multich_dump_collector

Overview:
- Sample-clock-domain collector for an NCH-channel correlator bank.
- Latches each channel's early/prompt/late I/Q accumulators and epoch on that channel's dump pulse.
- A round-robin arbiter moves the latched records into a synchronous FIFO, which presents them as a valid/ready record stream to the bus-side wrapper.
- Replaces per-channel direct register readout; provides per-channel overrun detection and a global drop count.

Parameters:
- NCH, 4: number of correlator channels (1..16).
- ACC_W, 18: accumulator width, signed.
- DEPTH, 16: FIFO depth in records; power of two, >= 2.
- CH_W, 4: channel-index width; must satisfy 2**CH_W >= NCH.

Ports:
- clk  in  1  sample clock, 16.368 MHz.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO, pending flags and arbiter pointer.
- dump  in  NCH  per-channel dump pulse, one cycle wide.
- acc_in  in  NCH*6*ACC_W  per channel, packed {ie,qe,ip,qp,il,ql}; channel c occupies slice c.
- epoch_in  in  NCH*16  per-channel epoch at dump.
- rec_valid  out  1  FIFO not empty.
- rec_ready  in  1  consumer accepts the record.
- rec_ch  out  CH_W  channel index of the head record.
- rec_acc  out  6*ACC_W  accumulators of the head record.
- rec_epoch  out  16  epoch of the head record.
- fifo_level  out  clog2(DEPTH)+1  occupancy.
- overrun  out  NCH  sticky per-channel overrun flags.
- ovr_clr  in  NCH  per-bit clear of overrun.
- drop_count  out  16  saturating count of overwritten records.

Behaviour:
- Reset (asynchronous): all pending flags, hold registers, FIFO pointers, rr_ptr, overrun and drop_count go to 0. rec_valid=0, fifo_level=0.
- Capture: on a clk edge with dump[c]=1, hold[c] <= {acc_in slice c, epoch_in slice c} and pending[c] <= 1.
- Grant: each cycle, if fifo_level < DEPTH and any pending bit is set, grant the first pending channel scanning upward from rr_ptr, wrapping modulo NCH.
  - Write {ch, hold[ch]} to the FIFO.
  - Clear pending[ch].
  - rr_ptr <= (ch+1) mod NCH.
  - At most one grant per cycle.
- Same-cycle grant and dump on the granted channel: the old hold is written to the FIFO, the new data is loaded, and pending stays 1. This is not an overrun.
- Overrun: dump[c]=1 while pending[c]=1 and c is not granted that cycle.
  - hold[c] is overwritten with the newest data.
  - overrun[c] <= 1.
  - drop_count increments, saturating at 0xFFFF. When several channels overrun in the same cycle, drop_count increments by their number, still saturating.
- ovr_clr[c] clears overrun[c]; a set in the same cycle wins.
- FIFO full: the write condition is fifo_level < DEPTH, evaluated before any same-cycle pop. A full FIFO with a concurrent pop does not accept a push that cycle. Records wait in pending/hold.
- Pop: occurs when rec_valid && rec_ready. rec_ch, rec_acc and rec_epoch are an asynchronous read of the head entry and remain stable while rec_valid=1 and rec_ready=0.
- Push and pop in the same cycle leave fifo_level unchanged. Pointers wrap modulo DEPTH.
- Latency: dump high at edge E0, grant at E1, rec_valid=1 after E1 (two edges, empty FIFO, no competing channel).
- flush: clears FIFO, pending and rr_ptr next edge; overrun and drop_count are kept. A dump in the flush cycle is discarded.
- Ordering: records from a single channel leave in dump order. Inter-channel order follows round-robin.

Optional Feature:
- GPS_DUMP_TSTAMP_EN defined:
  - Adds a 32-bit free-running sample counter (reset 0, wraps) and output rec_tstamp[31:0].
  - The counter value at the capture edge is stored with each record and carried through the FIFO.
- Undefined: no counter, no rec_tstamp port, record width unchanged.

Decomposition:
- Package gps_dump_pkg:
  - ACC_W default.
  - NACC=6.
  - Record field offsets and a packed struct typedef for {ch, acc, epoch[, tstamp]}.
  - Helper function rr_pick(pending, rr_ptr).
- Sub-module gps_sync_fifo: parametrised width/depth, distributed-RAM array, asynchronous read, level output.
- Capture/arbitration logic stays in this module.

Test Plan:
- NCH=4, single dump on ch2 with ip=0x1FFFF (max positive), epoch=0x0123 -> rec_valid after 2 edges, rec_ch=2, fields exact, fifo_level=1, popped in one cycle.
- All four dumps in the same cycle, rr_ptr=0, rec_ready=1 -> records emerge ch0,1,2,3 on consecutive cycles; rr_ptr ends at 0.
- rec_ready=0, DEPTH=16, 20 dumps round-robin -> fifo_level saturates at 16, 4 pending retained, no overrun until a second dump hits a pending channel; then overrun[c]=1, drop_count=1, and the newest data is delivered.
- Dump on ch1 in the exact cycle ch1 is granted -> two ch1 records in order, overrun=0, drop_count=0.
- Assert rstn low mid-stream with FIFO at 7 -> outputs immediately 0 (rec_valid=0, fifo_level=0, overrun=0); first post-reset dump behaves as in scenario 1.
- With GPS_DUMP_TSTAMP_EN: dumps 1000 cycles apart after reset -> rec_tstamp difference = 1000.
